path_traceback: RTL and testbench
=================================

# path_traceback

Walks a completed direction (P) memory backwards, from the bottom-right cell of a ROWS×COLS cost grid to the Start cell. The P memory was filled earlier by the shortest-path DP engine, which writes Start/Right/Down codes. At each visited cell the block writes that cell's linear index into a trace SRAM, so the trace holds the optimal path in reverse order. It sits after the DP engine on the same P SRAM port and is the reader side of that writer.

## Interface
- ROWS, 4, number of grid rows
- COLS, 4, number of grid columns (row stride in P)
- D_WIDTH, 8, SRAM data width
- A_WIDTH, 13, SRAM address width
- START_CODE, 8'h08, P code for the origin cell
- RIGHT_CODE, 8'h09, P code meaning "arrived from the left"
- DOWN_CODE, 8'h0A, P code meaning "arrived from above"

Ports:
- Clk  in  1  clock; all logic on the rising edge
- Rst  in  1  reset, synchronous, active-high
- Go  in  1  start request, sampled only in IDLE
- Base  in  A_WIDTH  P address of cell (0,0), captured on Go
- P_In  in  D_WIDTH  P SRAM read data
- P_Addr  out  A_WIDTH  P SRAM address
- P_En  out  1  P SRAM enable
- P_Rw  out  1  P SRAM read/write; always 0 (read)
- T_Out  out  D_WIDTH  trace write data: r*COLS+c, truncated to D_WIDTH
- T_Addr  out  A_WIDTH  trace write address = step index k
- T_En  out  1  trace SRAM enable
- T_Rw  out  1  trace read/write; 1 whenever T_En=1
- Len  out  A_WIDTH  number of trace entries written; valid when Done=1
- Done  out  1  one-cycle completion pulse
- Err  out  1  malformed path detected (see Configuration)

## Operation
- All outputs are registered. On reset every output is 0 (P_Addr, P_En, P_Rw, T_Out, T_Addr, T_En, T_Rw, Len, Done, Err). Internal r, c and k are also 0, and the state is IDLE.
- States: IDLE, RD, W1, W2, DEC, FIN.
- IDLE: when Go=1, capture Base, set r=ROWS-1, c=COLS-1, k=0, clear Err, and go to RD. When Go=0, stay in IDLE.
- RD: drive P_En=1, P_Rw=0, P_Addr=Base+r*COLS+c, then go to W1.
- W1: wait one cycle, then go to W2.
- W2: latch P_In into the code register, then go to DEC.
- DEC: drive T_En=1, T_Rw=1, T_Addr=k, T_Out=r*COLS+c, and increment k. Then branch on the code:
  - DOWN_CODE: r=r-1, go to RD.
  - RIGHT_CODE: c=c-1, go to RD.
  - START_CODE: go to FIN.
- FIN: drive Done=1 and Len=k for exactly one cycle, then go to IDLE. Len holds its value until the next Go.
- A legal path always gives Len = ROWS+COLS-1.
- Go while the block is not in IDLE is ignored.
- Rst asserted mid-walk takes effect on the next edge: the block returns to IDLE with all outputs 0, and no further trace writes occur.
- Address arithmetic is unsigned at A_WIDTH and wraps silently. Range checking is the caller's responsibility.

## Timing
- The P read is issued in cycle n. P_In is valid and sampled in cycle n+2 (W2).
- Each cell costs 4 cycles: RD, W1, W2, DEC.
- Go is sampled high at edge e0. The first RD is the cycle after e0. Done asserts (4·Len)+1 cycles after e0.
- For a 4×4 grid, Done is high 29 cycles after Go.
- P_En, T_En and Done are each high for a single cycle per event.
- The T write and the next P read never occur in the same cycle.

## Configuration
- PATH_CHECK_EN defined:
  - In DEC, each step is validated before it is taken. The following are illegal:
    - DOWN_CODE when r=0
    - RIGHT_CODE when c=0
    - START_CODE when (r,c)≠(0,0)
    - any other code value
  - On an illegal code the trace entry for that cell is still written. The block then goes to FIN, and Err=1 is asserted with Done. Err holds until the next accepted Go or Rst.
- PATH_CHECK_EN undefined:
  - Err is constant 0.
  - Any code other than DOWN_CODE or RIGHT_CODE is treated as START_CODE, and the walk terminates normally.
  - Out-of-bounds steps are not checked.

## Test plan
- Staircase path, 4×4. Row 0 holds Start,Right,Right,Right; every cell in rows 1–3 holds Down. Pulse Go with Base=0.
  - Required: trace writes T_Addr 0..6 with T_Out 15,11,7,3,2,1,0; Len=7; Err=0; Done 29 cycles after Go.
- Alternating path with Base=100. P codes are set so that from (3,3) the walk steps Right, Down, Right, Down, Right, Down.
  - Required: P_Addr sequence 115,114,110,109,105,104,100; T_Out 15,14,10,9,5,4,0.
- PATH_CHECK_EN defined, code 8'h00 placed at (2,3) on the path.
  - Required: T entries 15,11 written, then Done=1 with Err=1 and Len=2.
  - Without the macro, the same stimulus gives Done with Err=0 and Len=2.
- PATH_CHECK_EN defined, DOWN_CODE at (0,2) reached via the path.
  - Required: Err=1; no P read at address Base-2.
- Go re-asserted mid-walk, then Rst at cycle 10 of a second walk.
  - Required: the mid-walk Go is ignored and has no effect on the P_Addr sequence.
  - After Rst all outputs are 0, no T_En pulse follows, and a later Go restarts the walk from (3,3).

Source files
------------

// File: rtl/path_traceback.sv
// Reverse walk of a completed DP direction memory from (ROWS-1,COLS-1) to Start,
// writing each visited cell's linear index to a trace SRAM. Optional macro: PATH_CHECK_EN.
module path_traceback #(
  parameter int                 ROWS       = 4,
  parameter int                 COLS       = 4,
  parameter int                 D_WIDTH    = 8,
  parameter int                 A_WIDTH    = 13,
  parameter logic [D_WIDTH-1:0] START_CODE = 8'h08,
  parameter logic [D_WIDTH-1:0] RIGHT_CODE = 8'h09,
  parameter logic [D_WIDTH-1:0] DOWN_CODE  = 8'h0A
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [A_WIDTH-1:0] Base,
  input  logic [D_WIDTH-1:0] P_In,
  output logic [A_WIDTH-1:0] P_Addr,
  output logic               P_En,
  output logic               P_Rw,
  output logic [D_WIDTH-1:0] T_Out,
  output logic [A_WIDTH-1:0] T_Addr,
  output logic               T_En,
  output logic               T_Rw,
  output logic [A_WIDTH-1:0] Len,
  output logic               Done,
  output logic               Err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_W1, S_W2, S_DEC, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      r_q, r_d;
  logic [CW-1:0]      c_q, c_d;
  logic [A_WIDTH-1:0] k_q, k_d;
  logic [A_WIDTH-1:0] base_q, base_d;
  logic [D_WIDTH-1:0] code_q, code_d;
  logic [A_WIDTH-1:0] p_addr_q, p_addr_d;
  logic               p_en_q, p_en_d;
  logic [D_WIDTH-1:0] t_out_q, t_out_d;
  logic [A_WIDTH-1:0] t_addr_q, t_addr_d;
  logic               t_en_q, t_en_d;
  logic [A_WIDTH-1:0] len_q, len_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               go_accept;
  logic               illegal;

  function automatic logic [A_WIDTH-1:0] lin_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return A_WIDTH'(r) * A_WIDTH'(COLS) + A_WIDTH'(c);
  endfunction

  assign go_accept = (state_q == S_IDLE) && Go;

`ifdef PATH_CHECK_EN
  always_comb begin
    illegal = 1'b1;
    if (code_q == DOWN_CODE)       illegal = (r_q == '0);
    else if (code_q == RIGHT_CODE) illegal = (c_q == '0);
    else if (code_q == START_CODE) illegal = (r_q != '0) || (c_q != '0);
  end
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      base_q   <= '0;
      code_q   <= '0;
      p_addr_q <= '0;
      p_en_q   <= 1'b0;
      t_out_q  <= '0;
      t_addr_q <= '0;
      t_en_q   <= 1'b0;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      base_q   <= base_d;
      code_q   <= code_d;
      p_addr_q <= p_addr_d;
      p_en_q   <= p_en_d;
      t_out_q  <= t_out_d;
      t_addr_q <= t_addr_d;
      t_en_q   <= t_en_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    base_d  = base_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (Go) begin
          base_d  = Base;
          r_d     = RW'(ROWS - 1);
          c_d     = CW'(COLS - 1);
          k_d     = '0;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_W1;
      S_W1: state_d = S_W2;
      S_W2: begin
        code_d  = P_In;
        state_d = S_DEC;
      end
      S_DEC: begin
        k_d = k_q + A_WIDTH'(1);
        if (illegal) begin
          state_d = S_FIN;
        end else if (code_q == DOWN_CODE) begin
          r_d     = r_q - RW'(1);
          state_d = S_RD;
        end else if (code_q == RIGHT_CODE) begin
          c_d     = c_q - CW'(1);
          state_d = S_RD;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    p_en_d   = (state_d == S_RD);
    p_addr_d = p_en_d ? base_d + lin_idx(r_d, c_d) : '0;
    t_en_d   = (state_d == S_DEC);
    t_addr_d = t_en_d ? k_d : '0;
    t_out_d  = t_en_d ? D_WIDTH'(lin_idx(r_d, c_d)) : '0;
    done_d   = (state_d == S_FIN);
    len_d    = go_accept ? '0 : (done_d ? k_d : len_q);
`ifdef PATH_CHECK_EN
    err_d    = go_accept ? 1'b0 : (((state_q == S_DEC) && illegal) ? 1'b1 : err_q);
`else
    err_d    = 1'b0;
`endif
  end

  assign P_Addr = p_addr_q;
  assign P_En   = p_en_q;
  assign P_Rw   = 1'b0;
  assign T_Out  = t_out_q;
  assign T_Addr = t_addr_q;
  assign T_En   = t_en_q;
  assign T_Rw   = t_en_q;
  assign Len    = len_q;
  assign Done   = done_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_path_traceback.sv
// Scoreboard bench for path_traceback on a 4x4 grid; expected P reads and trace
// writes are queued per walk and popped against what the monitor captured.
module tb_path_traceback;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam logic [7:0] SC = 8'h08;
  localparam logic [7:0] RC = 8'h09;
  localparam logic [7:0] DC = 8'h0A;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Go = 1'b0;
  logic [AW-1:0] Base = '0;
  logic [DW-1:0] P_In;
  logic [AW-1:0] P_Addr, T_Addr, Len;
  logic [DW-1:0] T_Out;
  logic          P_En, P_Rw, T_En, T_Rw, Done, Err;

  logic [7:0] pmem [0:(1<<AW)-1];
  logic [7:0] rd1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int go_cyc = 0;
  int proto_bad = 0;

  logic [AW-1:0]    obs_p[$], exp_p[$];
  logic [AW+DW-1:0] obs_t[$], exp_t[$];
  int               obs_done[$];
  logic [AW-1:0]    obs_len[$];
  logic             obs_err[$];

  path_traceback dut (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Base(Base), .P_In(P_In),
    .P_Addr(P_Addr), .P_En(P_En), .P_Rw(P_Rw),
    .T_Out(T_Out), .T_Addr(T_Addr), .T_En(T_En), .T_Rw(T_Rw),
    .Len(Len), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Two-stage read: address in cycle n, data on P_In during cycle n+2.
  always @(posedge Clk) begin
    rd1  <= pmem[P_Addr];
    P_In <= rd1;
  end

  always @(negedge Clk) begin
    cyc++;
    if (P_Rw !== 1'b0 || T_Rw !== T_En || (P_En === 1'b1 && T_En === 1'b1)) proto_bad++;
    if (P_En === 1'b1) obs_p.push_back(P_Addr);
    if (T_En === 1'b1) begin
      obs_t.push_back({T_Addr, T_Out});
      $display("trace write k=%0d idx=%0d", T_Addr, T_Out);
    end
    if (Done === 1'b1) begin
      obs_done.push_back(cyc);
      obs_len.push_back(Len);
      obs_err.push_back(Err);
      $display("walk done len=%0d err=%0d after %0d cycles", Len, Err, cyc - go_cyc);
    end
  end

  task automatic clear_pmem();
    for (int i = 0; i < 256; i++) pmem[i] = 8'hFF;
  endtask

  task automatic fill_stair(input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pmem[base + r*4 + c] = (r != 0) ? DC : ((c == 0) ? SC : RC);
  endtask

  task automatic expect_cell(input int base, input int idx, input int k);
    exp_p.push_back(AW'(base + idx));
    exp_t.push_back({AW'(k), DW'(idx)});
  endtask

  task automatic start_walk(input int base);
    @(posedge Clk);
    #1;
    obs_p.delete(); obs_t.delete(); obs_done.delete(); obs_len.delete(); obs_err.delete();
    Base = AW'(base);
    Go = 1'b1;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    go_cyc = cyc;
  endtask

  task automatic wait_walk();
    for (int i = 0; i < 200 && obs_done.size() == 0; i++) @(negedge Clk);
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if ({P_En, P_Rw, T_En, T_Rw, Done, Err} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {P_En, P_Rw, T_En, T_Rw, Done, Err});
    end
    checks++; if (P_Addr !== '0 || T_Addr !== '0 || Len !== '0) begin
      failures++; $display("FAIL reset_addr got=%0d/%0d/%0d exp=0/0/0", P_Addr, T_Addr, Len);
    end
    checks++; if (T_Out !== '0) begin
      failures++; $display("FAIL reset_tout got=%0d exp=0", T_Out);
    end
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if ({P_En, T_En, Done} !== 3'b0) begin
      failures++; $display("FAIL idle_quiet got=%b exp=000", {P_En, T_En, Done});
    end
  endtask

  task automatic test_staircase();
    logic [AW-1:0] ea, oa;
    logic [AW+DW-1:0] et, ot;
    int idx[7] = '{15, 11, 7, 3, 2, 1, 0};
    clear_pmem();
    fill_stair(0);
    for (int k = 0; k < 7; k++) expect_cell(0, idx[k], k);
    start_walk(0);
    wait_walk();
    while (exp_p.size() > 0) begin
      ea = exp_p.pop_front(); oa = (obs_p.size() > 0) ? obs_p.pop_front() : 'x;
      checks++; if (oa !== ea) begin failures++; $display("FAIL stair_p_addr got=%0d exp=%0d", oa, ea); end
    end
    while (exp_t.size() > 0) begin
      et = exp_t.pop_front(); ot = (obs_t.size() > 0) ? obs_t.pop_front() : 'x;
      checks++; if (ot !== et) begin failures++; $display("FAIL stair_trace got=%h exp=%h", ot, et); end
    end
    checks++; if (obs_p.size() + obs_t.size() != 0) begin
      failures++; $display("FAIL stair_extra got=%0d exp=0", obs_p.size() + obs_t.size());
    end
    checks++; if (obs_done.size() != 1 || obs_done[0] - go_cyc != 29) begin
      failures++; $display("FAIL stair_done_latency got=%0d exp=29", (obs_done.size() > 0) ? obs_done[0] - go_cyc : -1);
    end
    checks++; if (obs_len.size() == 0 || obs_len[0] !== AW'(7) || obs_err[0] !== 1'b0) begin
      failures++; $display("FAIL stair_len_err got=%0d/%b exp=7/0", (obs_len.size() > 0) ? obs_len[0] : 'x, (obs_err.size() > 0) ? obs_err[0] : 1'bx);
    end
    checks++; if (Len !== AW'(7)) begin failures++; $display("FAIL stair_len_hold got=%0d exp=7", Len); end
  endtask

  task automatic test_alternating();
    logic [AW-1:0] ea, oa;
    logic [AW+DW-1:0] et, ot;
    int idx[7] = '{15, 14, 10, 9, 5, 4, 0};
    clear_pmem();
    pmem[115] = RC; pmem[114] = DC; pmem[110] = RC; pmem[109] = DC;
    pmem[105] = RC; pmem[104] = DC; pmem[100] = SC;
    for (int k = 0; k < 7; k++) expect_cell(100, idx[k], k);
    start_walk(100);
    wait_walk();
    while (exp_p.size() > 0) begin
      ea = exp_p.pop_front(); oa = (obs_p.size() > 0) ? obs_p.pop_front() : 'x;
      checks++; if (oa !== ea) begin failures++; $display("FAIL alt_p_addr got=%0d exp=%0d", oa, ea); end
    end
    while (exp_t.size() > 0) begin
      et = exp_t.pop_front(); ot = (obs_t.size() > 0) ? obs_t.pop_front() : 'x;
      checks++; if (ot !== et) begin failures++; $display("FAIL alt_trace got=%h exp=%h", ot, et); end
    end
    checks++; if (obs_len.size() != 1 || obs_len[0] !== AW'(7)) begin
      failures++; $display("FAIL alt_len got=%0d exp=7", (obs_len.size() > 0) ? obs_len[0] : 'x);
    end
  endtask

  task automatic test_bad_code();
    logic [AW-1:0] ea, oa;
    logic [AW+DW-1:0] et, ot;
    logic exp_err;
`ifdef PATH_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear_pmem();
    fill_stair(0);
    pmem[11] = 8'h00;
    expect_cell(0, 15, 0);
    expect_cell(0, 11, 1);
    start_walk(0);
    wait_walk();
    while (exp_p.size() > 0) begin
      ea = exp_p.pop_front(); oa = (obs_p.size() > 0) ? obs_p.pop_front() : 'x;
      checks++; if (oa !== ea) begin failures++; $display("FAIL bad_p_addr got=%0d exp=%0d", oa, ea); end
    end
    while (exp_t.size() > 0) begin
      et = exp_t.pop_front(); ot = (obs_t.size() > 0) ? obs_t.pop_front() : 'x;
      checks++; if (ot !== et) begin failures++; $display("FAIL bad_trace got=%h exp=%h", ot, et); end
    end
    checks++; if (obs_t.size() != 0) begin failures++; $display("FAIL bad_extra_trace got=%0d exp=0", obs_t.size()); end
    checks++; if (obs_done.size() != 1 || obs_len[0] !== AW'(2) || obs_err[0] !== exp_err) begin
      failures++; $display("FAIL bad_done got=%0d/%0d exp=2/%0d", (obs_len.size() > 0) ? obs_len[0] : 'x, (obs_err.size() > 0) ? obs_err[0] : 1'bx, exp_err);
    end
    checks++; if (Err !== exp_err) begin failures++; $display("FAIL bad_err_hold got=%b exp=%b", Err, exp_err); end
  endtask

`ifdef PATH_CHECK_EN
  task automatic test_out_of_bounds();
    logic [AW-1:0] ea, oa;
    logic [AW+DW-1:0] et, ot;
    int idx[5] = '{15, 11, 7, 3, 2};
    clear_pmem();
    pmem[65] = DC; pmem[61] = DC; pmem[57] = DC; pmem[53] = RC; pmem[52] = DC;
    for (int k = 0; k < 5; k++) expect_cell(50, idx[k], k);
    start_walk(50);
    wait_walk();
    while (exp_p.size() > 0) begin
      ea = exp_p.pop_front(); oa = (obs_p.size() > 0) ? obs_p.pop_front() : 'x;
      checks++; if (oa !== ea) begin failures++; $display("FAIL oob_p_addr got=%0d exp=%0d", oa, ea); end
    end
    while (exp_t.size() > 0) begin
      et = exp_t.pop_front(); ot = (obs_t.size() > 0) ? obs_t.pop_front() : 'x;
      checks++; if (ot !== et) begin failures++; $display("FAIL oob_trace got=%h exp=%h", ot, et); end
    end
    checks++; if (obs_p.size() != 0) begin failures++; $display("FAIL oob_extra_read got=%0d exp=0", obs_p.pop_front()); end
    checks++; if (obs_done.size() != 1 || obs_err[0] !== 1'b1 || obs_len[0] !== AW'(5)) begin
      failures++; $display("FAIL oob_done got=%0d/%b exp=5/1", (obs_len.size() > 0) ? obs_len[0] : 'x, (obs_err.size() > 0) ? obs_err[0] : 1'bx);
    end
  endtask
`endif

  task automatic test_midwalk_go_and_reset();
    logic [AW-1:0] ea, oa;
    int idx[7] = '{15, 11, 7, 3, 2, 1, 0};
    clear_pmem();
    fill_stair(0);
    for (int k = 0; k < 7; k++) expect_cell(0, idx[k], k);
    exp_t.delete();
    start_walk(0);
    repeat (5) @(posedge Clk);
    #1; Go = 1'b1; Base = AW'(200);
    @(posedge Clk);
    #1; Go = 1'b0; Base = '0;
    wait_walk();
    while (exp_p.size() > 0) begin
      ea = exp_p.pop_front(); oa = (obs_p.size() > 0) ? obs_p.pop_front() : 'x;
      checks++; if (oa !== ea) begin failures++; $display("FAIL midgo_p_addr got=%0d exp=%0d", oa, ea); end
    end
    checks++; if (obs_done.size() != 1 || obs_done[0] - go_cyc != 29 || obs_err[0] !== 1'b0) begin
      failures++; $display("FAIL midgo_done got=%0d exp=29", (obs_done.size() > 0) ? obs_done[0] - go_cyc : -1);
    end
    // Second walk is cut by reset at cycle 10.
    start_walk(0);
    repeat (9) @(posedge Clk);
    #1; Rst = 1'b1;
    @(posedge Clk);
    #1; Rst = 1'b0;
    obs_p.delete(); obs_t.delete(); obs_done.delete();
    checks++; if ({P_Addr, P_En, P_Rw, T_Out, T_Addr, T_En, T_Rw, Len, Done, Err} !== '0) begin
      failures++; $display("FAIL rst_outputs got=%h exp=0", {P_Addr, P_En, P_Rw, T_Out, T_Addr, T_En, T_Rw, Len, Done, Err});
    end
    repeat (40) @(negedge Clk);
    checks++; if (obs_t.size() + obs_p.size() + obs_done.size() != 0) begin
      failures++; $display("FAIL rst_quiet got=%0d exp=0", obs_t.size() + obs_p.size() + obs_done.size());
    end
    for (int k = 0; k < 7; k++) expect_cell(0, idx[k], k);
    exp_t.delete();
    start_walk(0);
    wait_walk();
    while (exp_p.size() > 0) begin
      ea = exp_p.pop_front(); oa = (obs_p.size() > 0) ? obs_p.pop_front() : 'x;
      checks++; if (oa !== ea) begin failures++; $display("FAIL restart_p_addr got=%0d exp=%0d", oa, ea); end
    end
    checks++; if (obs_len.size() != 1 || obs_len[0] !== AW'(7)) begin
      failures++; $display("FAIL restart_len got=%0d exp=7", (obs_len.size() > 0) ? obs_len[0] : 'x);
    end
  endtask

  task automatic test_protocol();
    checks++; if (proto_bad != 0) begin
      failures++; $display("FAIL rw_and_overlap got=%0d exp=0", proto_bad);
    end
  endtask

  initial begin
    clear_pmem();
    test_reset();
    test_staircase();
    test_alternating();
    test_bad_code();
`ifdef PATH_CHECK_EN
    test_out_of_bounds();
`endif
    test_midwalk_go_and_reset();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
